// File: rtl/neopixel_frame_sched.sv
// neopixel_frame_sched
// Schedules WS2812 frame transmissions from a double-buffered frame store.
// A writer fills the back buffer and pulses i_wr_done. This block swaps the
// buffers only when no frame is streaming. It streams LEDS*3 bytes to the bit
// encoder and holds the line low for LATCH_CYCLES clocks. It can also re-stream
// the current frame continuously.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_wr_done           writer finished a frame (single-cycle pulse)
//   i_auto_refresh      re-stream the current frame while no new frame pends
//   o_swap              single-cycle swap pulse to the double buffer
//   o_wr_hold           writer must stay off the buffer while high
//   i_frame_valid       double buffer confirms the swapped frame is readable
//   o_rd_addr/i_rd_data byte read port (combinational data)
//   o_byte/o_byte_valid/i_byte_ready  valid/ready byte stream to the encoder
//   i_enc_idle          encoder has finished shifting the last bit
//   o_busy              high in every state except IDLE
//   o_overrun           sticky: i_wr_done arrived while o_wr_hold was high
//   o_frames_sent       completed frame count, wraps
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | nothing streaming, waiting for a pending frame
// SWAP        | one-cycle swap pulse, clears pending, rewinds address
// WAIT_VALID  | waiting for the double buffer's frame-valid pulse
// SEND        | streaming bytes 0..LEDS*3-1 to the encoder
// WAIT_IDLE   | last byte accepted, encoder still shifting bits
// LATCH       | line held low for LATCH_CYCLES clocks
module neopixel_frame_sched #(
  parameter int LEDS         = 30,
  parameter int ADDR_WIDTH   = $clog2(LEDS*3),
  parameter int LATCH_CYCLES = 2400
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_done,
  input  logic                  i_auto_refresh,
  output logic                  o_swap,
  output logic                  o_wr_hold,
  input  logic                  i_frame_valid,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [7:0]            i_rd_data,
  output logic [7:0]            o_byte,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  input  logic                  i_enc_idle,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic [7:0]            o_frames_sent
);

  localparam int CNT_W = $clog2(LATCH_CYCLES+1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LEDS*3-1);
  localparam logic [CNT_W-1:0]      LATCH_LOAD = CNT_W'(LATCH_CYCLES-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWAP,
    S_WAIT_VALID,
    S_SEND,
    S_WAIT_IDLE,
    S_LATCH
  } state_t;

  state_t                  state_q, state_d;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              byte_q, byte_d;
  logic                    bvalid_q, bvalid_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              frames_q, frames_d;

  logic handshake;
  logic last_byte;
  logic latch_done;
  logic wr_hold;

  assign handshake  = bvalid_q & i_byte_ready;
  assign last_byte  = (addr_q == LAST_ADDR);
  assign latch_done = (cnt_q == '0);
  assign wr_hold    = pending_q | (state_q == S_SWAP);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q) state_d = S_SWAP;
      end
      S_SWAP: begin
        state_d = S_WAIT_VALID;
      end
      S_WAIT_VALID: begin
        if (i_frame_valid) state_d = S_SEND;
      end
      S_SEND: begin
        if (handshake && last_byte) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (i_enc_idle) state_d = S_LATCH;
      end
      S_LATCH: begin
        // A new frame wins over auto-refresh; auto-refresh restarts the
        // stream from the buffer that is already being shown.
        if (latch_done) begin
          if (pending_q)           state_d = S_SWAP;
          else if (i_auto_refresh) state_d = S_SEND;
          else                     state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath next values
  always_comb begin
    o_swap    = (state_q == S_SWAP);
    o_wr_hold = wr_hold;
    o_busy    = (state_q != S_IDLE);

    pending_d = pending_q;
    overrun_d = overrun_q;
    addr_d    = addr_q;
    byte_d    = byte_q;
    bvalid_d  = bvalid_q;
    cnt_d     = cnt_q;
    frames_d  = frames_q;

    // A write-done pulse is accepted in any state. The swap it requests waits
    // until the FSM reaches IDLE or the end of LATCH.
    if (i_wr_done) begin
      if (wr_hold) overrun_d = 1'b1;
      else         pending_d = 1'b1;
    end

    case (state_q)
      S_SWAP: begin
        pending_d = 1'b0;
        addr_d    = '0;
      end
      S_SEND: begin
        // Fetch and hand over alternate, which limits the stream to one
        // byte every two clocks. The address advances only after acceptance,
        // so o_rd_addr always names the byte on o_byte.
        if (!bvalid_q) begin
          byte_d   = i_rd_data;
          bvalid_d = 1'b1;
        end else if (i_byte_ready) begin
          bvalid_d = 1'b0;
          if (!last_byte) addr_d = addr_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (i_enc_idle) cnt_d = LATCH_LOAD;
      end
      S_LATCH: begin
        if (latch_done) begin
          frames_d = frames_q + 8'd1;
          if (!pending_q && i_auto_refresh) addr_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      addr_q    <= '0;
      byte_q    <= '0;
      bvalid_q  <= 1'b0;
      cnt_q     <= '0;
      frames_q  <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      addr_q    <= addr_d;
      byte_q    <= byte_d;
      bvalid_q  <= bvalid_d;
      cnt_q     <= cnt_d;
      frames_q  <= frames_d;
    end
  end

  assign o_rd_addr     = addr_q;
  assign o_byte        = byte_q;
  assign o_byte_valid  = bvalid_q;
  assign o_overrun     = overrun_q;
  assign o_frames_sent = frames_q;

endmodule

// File: tb/tb_neopixel_frame_sched.sv
// Directed bench for neopixel_frame_sched with a byte scoreboard. The latch
// time is shortened so the 256-frame wrap test stays short.
module tb_neopixel_frame_sched;

  localparam int LEDS  = 30;
  localparam int NB    = LEDS*3;
  localparam int LATCH = 24;
  localparam int AW    = $clog2(NB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_done = 1'b0;
  logic          auto_ref = 1'b0;
  logic          byte_ready = 1'b1;
  logic          enc_idle = 1'b1;
  logic          stray_fv = 1'b0;
  logic          frame_valid;
  logic          swap, wr_hold, byte_valid, busy, overrun;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data, byte_o, frames;

  // Double-buffer model: swap flips the read bank, valid follows 2 clocks on.
  logic       bank = 1'b0;
  logic [1:0] fv_pipe = 2'b00;

  assign frame_valid = fv_pipe[1] | stray_fv;
  assign rd_data     = 8'(rd_addr) ^ (bank ? 8'hA5 : 8'h3C);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    fv_pipe <= {fv_pipe[0], swap};
    if (swap) bank <= ~bank;
  end

  neopixel_frame_sched #(
    .LEDS(LEDS),
    .ADDR_WIDTH(AW),
    .LATCH_CYCLES(LATCH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_wr_done(wr_done),
    .i_auto_refresh(auto_ref),
    .o_swap(swap),
    .o_wr_hold(wr_hold),
    .i_frame_valid(frame_valid),
    .o_rd_addr(rd_addr),
    .i_rd_data(rd_data),
    .o_byte(byte_o),
    .o_byte_valid(byte_valid),
    .i_byte_ready(byte_ready),
    .i_enc_idle(enc_idle),
    .o_busy(busy),
    .o_overrun(overrun),
    .o_frames_sent(frames)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   swap_cnt = 0;
  logic exp_bank = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Scoreboard monitor: one pop per accepted byte.
  always @(negedge clk) begin
    if (swap) swap_cnt++;
    if (!rst && byte_valid && byte_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_byte: got addr %0d data %0h, required no byte", rd_addr, byte_o);
      end else begin
        mon_e = sb.pop_front();
        check("byte_addr", 32'(rd_addr), 32'(mon_e.addr));
        check("byte_data", 32'(byte_o), 32'(mon_e.data));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic b);
    exp_t e;
    for (int a = 0; a < NB; a++) begin
      e.addr = AW'(a);
      e.data = 8'(a) ^ (b ? 8'hA5 : 8'h3C);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_wr_done;
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      tick;
      n++;
    end
    if (sb.size() != 0) begin
      timeout_fail(name);
      sb.delete();
    end
  endtask

  task automatic wait_not_busy(input string name, output int n);
    n = 0;
    while (busy && n < 2000) begin
      tick;
      n++;
    end
    if (busy) timeout_fail(name);
  endtask

  task automatic wait_addr(input string name, input int a);
    int n = 0;
    while (!(byte_valid && rd_addr == AW'(a)) && n < 2000) begin
      tick;
      n++;
    end
    if (n >= 2000) timeout_fail(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_swap"},     32'(swap), 0);
    check({tag, "_wr_hold"},  32'(wr_hold), 0);
    check({tag, "_rd_addr"},  32'(rd_addr), 0);
    check({tag, "_byte"},     32'(byte_o), 0);
    check({tag, "_bvalid"},   32'(byte_valid), 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_overrun"},  32'(overrun), 0);
    check({tag, "_frames"},   32'(frames), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, s, prev;
    logic [7:0]    st_byte;
    logic [AW-1:0] st_addr;
    logic          bad, hold_bad;

    repeat (3) tick;
    check_reset_outputs("rst");
    rst = 1'b0;
    tick;

    // Single frame from IDLE
    exp_bank = ~exp_bank;
    push_frame(exp_bank);
    s = swap_cnt;
    pulse_wr_done;
    check("hold_after_wr_done", 32'(wr_hold), 1);
    wait_drain("f1_drain");
    wait_not_busy("f1_idle", n);
    check("latch_clocks", n, LATCH + 1);
    check("f1_frames", 32'(frames), 1);
    check("f1_swaps", swap_cnt - s, 1);
    check("f1_hold_clear", 32'(wr_hold), 0);

    // Frame-valid outside WAIT_VALID
    stray_fv = 1'b1;
    tick;
    stray_fv = 1'b0;
    repeat (3) tick;
    check("stray_fv_busy", 32'(busy), 0);

    // Second write-done while held
    exp_bank = ~exp_bank;
    push_frame(exp_bank);
    s = swap_cnt;
    wr_done = 1'b1;
    tick;
    tick;
    wr_done = 1'b0;
    check("overrun_set", 32'(overrun), 1);
    wait_drain("f2_drain");
    wait_not_busy("f2_idle", n);
    check("f2_swaps", swap_cnt - s, 1);
    check("f2_frames", 32'(frames), 2);

    // Write-done mid-SEND and encoder stall
    exp_bank = ~exp_bank;
    push_frame(exp_bank);
    s = swap_cnt;
    pulse_wr_done;
    wait_addr("f3_addr20", 20);
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    exp_bank = ~exp_bank;
    push_frame(exp_bank);
    hold_bad = !wr_hold;
    wait_addr("f3_addr30", 30);
    byte_ready = 1'b0;
    st_byte = byte_o;
    st_addr = rd_addr;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (byte_o !== st_byte || rd_addr !== st_addr || byte_valid !== 1'b1) bad = 1'b1;
      if (!wr_hold) hold_bad = 1'b1;
    end
    byte_ready = 1'b1;
    check("stall_stable", 32'(bad), 0);
    check("stall_addr", 32'(st_addr), 30);
    n = 0;
    while (swap_cnt == s + 1 && n < 2000) begin
      tick;
      n++;
      if (!wr_hold && swap_cnt == s + 1) hold_bad = 1'b1;
    end
    if (n >= 2000) timeout_fail("f3_second_swap");
    check("hold_until_swap", 32'(hold_bad), 0);
    check("swap_after_latch_frames", 32'(frames), 3);
    wait_drain("f4_drain");
    wait_not_busy("f4_idle", n);
    check("f4_frames", 32'(frames), 4);
    check("f3f4_swaps", swap_cnt - s, 2);

    // Reset at byte 45
    exp_bank = ~exp_bank;
    push_frame(exp_bank);
    pulse_wr_done;
    wait_addr("f5_addr45", 45);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    tick;
    tick;
    rst = 1'b0;
    s = swap_cnt;
    repeat (50) tick;
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_swaps", swap_cnt - s, 0);

    // Auto refresh with frame counter wrap
    auto_ref = 1'b1;
    exp_bank = ~exp_bank;
    push_frame(exp_bank);
    s = swap_cnt;
    pulse_wr_done;
    for (int f = 1; f <= 256; f++) begin
      wait_drain("auto_drain");
      prev = int'(frames);
      if (f == 256) auto_ref = 1'b0;
      else          push_frame(exp_bank);
      n = 0;
      while (int'(frames) == prev && n < 500) begin
        tick;
        n++;
      end
      if (n >= 500) timeout_fail("auto_frame_end");
      if (f == 255) check("frames_255", 32'(frames), 255);
    end
    check("frames_wrap", 32'(frames), 0);
    wait_not_busy("auto_idle", n);
    check("auto_swaps", swap_cnt - s, 1);
    check("auto_idle_busy", 32'(busy), 0);

    repeat (5) tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/neopixel_frame_sched.md
NEOPIXEL_FRAME_SCHED -- requirements
Module: neopixel_frame_sched

Interface
REQ-001 SHALL have parameter LEDS, default 30, number of LEDs (3 bytes each, GRB order as stored).
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(LEDS*3), width of the buffer byte address.
REQ-003 SHALL have parameter LATCH_CYCLES, default 2400, low-time clocks after the last bit (50 us at 48 MHz).
REQ-004 SHALL have one clock and an asynchronous active-high reset.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst  in  1  asynchronous reset, active-high.
REQ-007 i_wr_done  in  1  single-cycle pulse from writer: frame fully written.
REQ-008 i_auto_refresh  in  1  1 = re-stream the current frame continuously.
REQ-009 o_swap  out  1  single-cycle pulse to the double buffer's frame-done/swap input.
REQ-010 o_wr_hold  out  1  writer must not write or pulse i_wr_done while high.
REQ-011 i_frame_valid  in  1  double buffer's read-frame-valid pulse (arrives 2 clocks after o_swap).
REQ-012 o_rd_addr  out  ADDR_WIDTH  read address to the double buffer.
REQ-013 i_rd_data  in  8  combinational read data for o_rd_addr.
REQ-014 o_byte  out  8  byte to the WS2812 bit encoder.
REQ-015 o_byte_valid  out  1  o_byte valid; held until accepted.
REQ-016 i_byte_ready  in  1  encoder accepts o_byte when high with o_byte_valid.
REQ-017 i_enc_idle  in  1  encoder has shifted out all bits.
REQ-018 o_busy  out  1  high in any state except IDLE.
REQ-019 o_overrun  out  1  sticky: i_wr_done received while o_wr_hold high.
REQ-020 o_frames_sent  out  8  count of completed frame transmissions, wraps 255->0.

Function
REQ-021 States: IDLE, SWAP, WAIT_VALID, SEND, WAIT_IDLE, LATCH.
REQ-022 i_wr_done while o_wr_hold low SHALL set a pending flag; o_wr_hold = pending OR state==SWAP.
REQ-023 i_wr_done while o_wr_hold high SHALL be ignored and set o_overrun (until reset).
REQ-024 A swap SHALL occur only from IDLE, or at LATCH end; never during SEND, WAIT_IDLE or mid-LATCH.
REQ-025 IDLE: pending -> SWAP; else stay.
REQ-026 SWAP (1 cycle): o_swap=1, pending cleared, o_rd_addr=0 -> WAIT_VALID.
REQ-027 WAIT_VALID: i_frame_valid -> SEND; no timeout.
REQ-028 SEND with o_byte_valid low: o_byte <= i_rd_data, o_byte_valid <= 1 next edge.
REQ-029 On handshake (valid & ready): o_byte_valid <= 0; if o_rd_addr == LEDS*3-1 -> WAIT_IDLE, else o_rd_addr +1; max 1 byte per 2 clocks.
REQ-030 WAIT_IDLE: i_enc_idle -> LATCH, latch counter loaded LATCH_CYCLES-1.
REQ-031 LATCH: counter decrements; at 0: o_frames_sent +1; pending -> SWAP; else i_auto_refresh -> SEND with o_rd_addr=0 (no swap); else IDLE.
REQ-032 LATCH counter width SHALL be $clog2(LATCH_CYCLES+1); LATCH lasts exactly LATCH_CYCLES clocks.
REQ-033 i_wr_done arriving in any state SHALL be captured as pending; swap deferred per REQ-024.
REQ-034 i_frame_valid outside WAIT_VALID SHALL be ignored.
REQ-035 o_rd_addr SHALL never exceed LEDS*3-1.

Reset
REQ-036 Asserting i_rst at any time SHALL immediately force IDLE, pending=0, o_swap=0, o_wr_hold=0, o_rd_addr=0, o_byte=0, o_byte_valid=0, o_overrun=0, o_frames_sent=0, latch counter=0.
REQ-037 Reset mid-SEND SHALL abandon the frame without a count increment; after release the block waits in IDLE for i_wr_done.

Verification
REQ-038 i_wr_done in IDLE -> o_wr_hold high next cycle, o_swap one pulse, i_frame_valid 2 cycles later, 90 bytes addr 0..89 in order, o_frames_sent=1 after 2400 LATCH clocks, back to IDLE.
REQ-039 i_wr_done mid-SEND -> no o_swap until LATCH end, then immediate SWAP; o_wr_hold high throughout.
REQ-040 Second i_wr_done while o_wr_hold high -> o_overrun=1, only one o_swap issued.
REQ-041 i_auto_refresh=1, no new frame -> frames repeat with o_swap never pulsing; o_frames_sent 255 -> 0 wrap checked.
REQ-042 i_byte_ready held low 100 clocks mid-frame -> o_byte and o_byte_valid stable, o_rd_addr unchanged.
REQ-043 i_rst asserted at byte 45 -> all outputs at reset values same cycle; after release no transmission until i_wr_done.
